// File: rtl/counter_pkg.sv
// Shared definitions for the counter datapath: rate-select codes and the
// period lookup used by the enable divider.
package counter_pkg;

  localparam logic [1:0] SPD_FULL = 2'b00;
  localparam logic [1:0] SPD_1HZ  = 2'b01;
  localparam logic [1:0] SPD_HALF = 2'b10;
  localparam logic [1:0] SPD_QTR  = 2'b11;

  // Period in clock cycles for a rate code. The result is 64 bits wide so that
  // callers can narrow it to their own counter width without losing bits.
  function automatic logic [63:0] period_of(input logic [1:0] speed,
                                            input int unsigned div_1hz);
    logic [63:0] base;
    base = 64'(div_1hz);
    case (speed)
      SPD_FULL: return 64'd1;
      SPD_1HZ:  return base;
      SPD_HALF: return base * 64'd2;
      default:  return base * 64'd4;
    endcase
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Enable-pulse divider: produces a registered one-cycle Enable every N
// Run-high cycles, where N is selected by Speed.
module rate_divider
  import counter_pkg::*;
#(
  parameter int unsigned DIV_1HZ = 50_000_000,
  parameter int unsigned COUNT_W = $clog2(4 * DIV_1HZ)
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] Speed,
  input  logic       Run,
  output logic       Enable
);

  // Reload values are N-1, computed at elaboration time at full counter width.
  localparam logic [COUNT_W-1:0] RELOAD_FULL =
    COUNT_W'(period_of(SPD_FULL, DIV_1HZ) - 64'd1);
  localparam logic [COUNT_W-1:0] RELOAD_1HZ =
    COUNT_W'(period_of(SPD_1HZ, DIV_1HZ) - 64'd1);
  localparam logic [COUNT_W-1:0] RELOAD_HALF =
    COUNT_W'(period_of(SPD_HALF, DIV_1HZ) - 64'd1);
  localparam logic [COUNT_W-1:0] RELOAD_QTR =
    COUNT_W'(period_of(SPD_QTR, DIV_1HZ) - 64'd1);

  logic [COUNT_W-1:0] rate_count;
  logic [1:0]         speed_q;

  function automatic logic [COUNT_W-1:0] reload_of(input logic [1:0] s);
    case (s)
      SPD_FULL: return RELOAD_FULL;
      SPD_1HZ:  return RELOAD_1HZ;
      SPD_HALF: return RELOAD_HALF;
      default:  return RELOAD_QTR;
    endcase
  endfunction

  // A rate change restarts the period even while paused, and suppresses a
  // pulse that would otherwise fall on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rate_count <= reload_of(Speed);
      speed_q    <= Speed;
      Enable     <= 1'b0;
    end else if (Speed != speed_q) begin
      rate_count <= reload_of(Speed);
      speed_q    <= Speed;
      Enable     <= 1'b0;
    end else if (!Run) begin
      Enable     <= 1'b0;
    end else if (rate_count == '0) begin
      rate_count <= reload_of(speed_q);
      Enable     <= 1'b1;
    end else begin
      rate_count <= rate_count - 1'b1;
      Enable     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rate_divider.sv
// Directed bench for rate_divider with DIV_1HZ=4 (periods 1, 4, 8, 16).
module tb_rate_divider;

  logic       Clock;
  logic       Reset;
  logic [1:0] Speed;
  logic       Run;
  logic       Enable;

  int checks;
  int failures;
  int pulse_cnt;

  rate_divider #(.DIV_1HZ(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Speed (Speed),
    .Run   (Run),
    .Enable(Enable)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // One rising edge, then sample Enable 1 time unit later.
  task automatic tick_expect(input logic exp, input string tag);
    @(posedge Clock);
    #1;
    checks++;
    if (Enable === 1'b1) pulse_cnt++;
    assert (Enable === exp) else begin
      failures++;
      $error("FAIL %s: Enable observed=%b expected=%b", tag, Enable, exp);
    end
  endtask

  task automatic expect_pulses(input int period, input int count, input string tag);
    for (int p = 0; p < count; p++)
      for (int i = 1; i <= period; i++)
        tick_expect(i == period, tag);
  endtask

  task automatic do_reset(input logic [1:0] spd, input int cycles, input string tag);
    Speed = spd;
    Run   = 1'b1;
    Reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick_expect(1'b0, tag);
    Reset = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pulse_cnt = 0;
    Reset = 1'b1;
    Speed = 2'b01;
    Run   = 1'b1;

    // 1: reset 3 cycles at 1 Hz, pulses every 4, downstream count 3 after 12
    do_reset(2'b01, 3, "reset_hold");
    pulse_cnt = 0;
    expect_pulses(4, 3, "s1hz_period");
    checks++;
    assert (pulse_cnt === 3) else begin
      failures++;
      $error("FAIL s1hz_count: pulses observed=%0d expected=%0d", pulse_cnt, 3);
    end

    // 2: full speed, Enable every edge
    do_reset(2'b00, 1, "full_reset");
    for (int i = 0; i < 6; i++) tick_expect(1'b1, "full_every");

    // 3: pause for 5 cycles with count at 2
    do_reset(2'b01, 1, "pause_reset");
    tick_expect(1'b0, "pause_pre");
    Run = 1'b0;
    for (int i = 0; i < 5; i++) tick_expect(1'b0, "pause_hold");
    Run = 1'b1;
    tick_expect(1'b0, "pause_resume1");
    tick_expect(1'b0, "pause_resume2");
    tick_expect(1'b1, "pause_resume3");
    expect_pulses(4, 1, "pause_after");

    // 4: switch 01->11 on the count==0 edge
    do_reset(2'b01, 1, "sw_reset");
    for (int i = 0; i < 3; i++) tick_expect(1'b0, "sw_pre");
    Speed = 2'b11;
    tick_expect(1'b0, "sw_edge_nopulse");
    expect_pulses(16, 2, "sw_qtr_period");

    // 5: one-cycle reset mid-period at half rate
    do_reset(2'b10, 1, "mid_reset_init");
    for (int i = 0; i < 3; i++) tick_expect(1'b0, "mid_pre");
    Reset = 1'b1;
    tick_expect(1'b0, "mid_reset_edge");
    Reset = 1'b0;
    expect_pulses(8, 1, "mid_after");

    // 6: speed change while paused reloads, then holds
    do_reset(2'b01, 1, "sp_reset");
    tick_expect(1'b0, "sp_pre");
    Run   = 1'b0;
    Speed = 2'b10;
    tick_expect(1'b0, "sp_change_edge");
    for (int i = 0; i < 3; i++) tick_expect(1'b0, "sp_hold");
    Run = 1'b1;
    expect_pulses(8, 1, "sp_resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
